// File: rtl/booth_radix4_seq_mult.sv
`default_nettype none
// ============================================================================
// Module      : booth_radix4_seq_mult
// Description : Sequential radix-4 Booth signed multiplier. One Booth digit
//               is retired per cycle, so a WIDTH x WIDTH signed product
//               (2*WIDTH bits) completes in WIDTH/2 accumulation cycles.
//               The running multiplicand is shifted left by two each cycle
//               (two-bit left-shift stage); the product register holds its
//               value until the next completion.
// Ports       : clk     - clock, all state updates on rising edge
//               reset   - asynchronous active-high reset, clears all state
//               start   - operation request, sampled only in IDLE
//               a       - signed multiplicand (WIDTH bits)
//               b       - signed multiplier (WIDTH bits)
//               busy    - high while accumulating (RUN)
//               done    - one-cycle pulse when product is updated
//               product - signed product (2*WIDTH bits), held
// Revision    : 1.0 - initial release
// ============================================================================
module booth_radix4_seq_mult #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int c_PW    = 2 * WIDTH;
    localparam int c_QW    = WIDTH + 2;
    localparam int c_CNT_W = $clog2(WIDTH / 2);

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_PW-1:0]    c_PW_ONE   = c_PW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_PW-1:0]     r_m;
    logic [c_QW-1:0]     r_q;
    logic [c_PW-1:0]     r_acc;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_PW-1:0]     r_product;
    logic                r_busy;
    logic                r_done;

    logic [c_PW-1:0]     w_m2;
    logic [c_PW-1:0]     w_pp;
    logic [c_PW-1:0]     w_acc_sum;
    logic                w_last;

    // ------------------------------------------------------------------
    // Booth digit decode and partial product selection
    // ------------------------------------------------------------------
    assign w_m2   = r_m << 1;
    assign w_last = (r_cnt == c_CNT_LAST);

    always_comb begin
        w_pp = '0;
        unique case (r_q[2:0])
            3'b000, 3'b111: w_pp = '0;
            3'b001, 3'b010: w_pp = r_m;
            3'b011:         w_pp = w_m2;
            3'b100:         w_pp = ~w_m2 + c_PW_ONE;
            3'b101, 3'b110: w_pp = ~r_m + c_PW_ONE;
            default:        w_pp = '0;
        endcase
    end

    // Modulo 2^(2*WIDTH) accumulation; carry out is intentionally dropped.
    assign w_acc_sum = r_acc + w_pp;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (start)  w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State, datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_m       <= '0;
            r_q       <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_product <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // Flags are derived from the next state so they line up with
            // the state they describe while staying register outputs.
            r_busy  <= (w_state_nxt == S_RUN);
            r_done  <= (w_state_nxt == S_DONE);

            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_m   <= {{WIDTH{a[WIDTH-1]}}, a};
                        r_q   <= {b[WIDTH-1], b, 1'b0};
                        r_acc <= '0;
                        r_cnt <= '0;
                    end
                end
                S_RUN: begin
                    r_acc <= w_acc_sum;
                    r_m   <= r_m << 2;
                    r_q   <= {r_q[c_QW-1], r_q[c_QW-1], r_q[c_QW-1:2]};
                    r_cnt <= r_cnt + c_CNT_ONE;
                    // Capture includes the last digit's contribution.
                    if (w_last) begin
                        r_product <= w_acc_sum;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_product;

endmodule
`default_nettype wire

// File: doc/booth_radix4_seq_mult.md
# booth_radix4_seq_mult

Sequential radix-4 Booth signed multiplier for the Wallace-tree multiplier datapath. It feeds the two-bit left-shift stage with the running multiplicand and consumes the shifted result. Each cycle it retires one Booth digit, so a WIDTH x WIDTH signed product (2*WIDTH bits, 32 at default) completes in WIDTH/2 accumulation cycles. It has a start/busy/done handshake and a held product register.

## Interface
- WIDTH, 16, operand width in bits; must be even and >= 4; product is 2*WIDTH bits.

- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state and outputs
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  signed multiplicand, two's complement
- b  input  WIDTH  signed multiplier, two's complement
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse; product valid and updated
- product  output  2*WIDTH  signed product, held until the next completion

## Operation
- States: IDLE, RUN, DONE.
- IDLE with start=1 loads the registers, clears digit counter cnt to 0, and moves to RUN. In IDLE, start=0 stays in IDLE.
  - M: a sign-extended to 2*WIDTH.
  - Q: {b[WIDTH-1], b, 1'b0}, i.e. WIDTH+2 bits.
  - acc: 0.
- RUN, each cycle:
  - Booth digit d = Q[2:0]. 000/111 -> 0; 001/010 -> +M; 011 -> +2M; 100 -> -2M; 101/110 -> -M.
  - 2M = M<<1. Negation is two's complement (~x+1).
  - acc <= acc + pp, modulo 2^(2*WIDTH), overflow discarded.
  - M <= M<<2, zero fill, upper 2 bits dropped (the two-bit left-shift stage).
  - Q <= Q>>>2, arithmetic.
  - cnt <= cnt+1.
- RUN exits to DONE after the cycle with cnt == WIDTH/2-1, which is the WIDTH/2-th accumulation.
- Entering DONE: product <= final acc, including that last digit's addition.
- DONE: done=1 for exactly one cycle, then unconditionally to IDLE.
- start is ignored in RUN and DONE. It is not queued.
- a and b are sampled only on the accepting edge. Later changes do not affect an operation in flight.
- product is unchanged from the accepting edge until the DONE-entry edge, then holds until the next DONE.
- Result equals the exact signed product a*b for all operand pairs, including -2^(WIDTH-1) * -2^(WIDTH-1).

## Timing
- Reset values: busy=0, done=0, product=0, acc=0, M=0, Q=0, cnt=0, state=IDLE.
- Reset asserted mid-RUN or in DONE aborts immediately, with no done pulse. product returns to 0.
- Cycle numbering: cycle 0 is the cycle with start=1 in IDLE.
  - busy=1 in cycles 1..WIDTH/2 (1..8 at default).
  - done=1 and new product visible in cycle WIDTH/2+1 (cycle 9); busy=0 in that cycle.
  - IDLE in cycle WIDTH/2+2. Earliest next accepted start is that cycle.
- Throughput: one product per WIDTH/2+2 cycles with back-to-back starts.
- busy and done are never both high.
- done is never high in two consecutive cycles.
- All outputs are registered. No combinational path from inputs to outputs.

## Test plan
- 3 x 5: start in cycle 0 -> busy cycles 1-8, done in cycle 9 with product=0x0000000F. product=0 before that.
- -7 x 6 (a=0xFFF9, b=0x0006) -> product=0xFFFFFFD6. Also 0 x 0x8000 -> 0x00000000.
- Extremes:
  - 0x8000 x 0x8000 -> 0x40000000.
  - 0x7FFF x 0x8000 -> 0xC0008000.
  - 0x7FFF x 0x7FFF -> 0x3FFF0001.
  - 0xFFFF x 0xFFFF -> 0x00000001.
- Pulse start=1 with a=2, b=2 in cycles 3 and 9 of a 3 x 5 operation, and change a/b mid-run -> only 0x0000000F is produced. Single done pulse; no second operation.
- Reset in cycle 4 of a run -> busy=0, product=0 immediately; no done. A fresh 0x1234 x 0x0010 afterwards -> 0x00012340.
- Random sweep of 10,000 signed pairs with starts back-to-back at the earliest cycle -> every product matches the reference a*b. done exactly every 10 cycles.
